// File: rtl/rx_ctrl_module_if.sv
// Signal bundle between the UART RX pin/baud counter environment and rx_ctrl_module.
// The slave modport is the receive controller's view; master is the environment's.
interface rx_ctrl_module_if #(
    parameter int DATA_BITS = 8
);
    logic                 RX_Pin_In;
    logic                 RX_En_Sig;
    logic                 BPS_CLK;
    logic                 Count_Sig;
    logic [DATA_BITS-1:0] RX_Data;
    logic                 RX_Done_Sig;
    logic                 Frame_Err;

    modport master (
        output RX_Pin_In,
        output RX_En_Sig,
        output BPS_CLK,
        input  Count_Sig,
        input  RX_Data,
        input  RX_Done_Sig,
        input  Frame_Err
    );

    modport slave (
        input  RX_Pin_In,
        input  RX_En_Sig,
        input  BPS_CLK,
        output Count_Sig,
        output RX_Data,
        output RX_Done_Sig,
        output Frame_Err
    );
endinterface

// File: rtl/rx_ctrl_module.sv
// UART receive controller: synchronizes the RX line, detects the start bit, runs the
// baud counter and samples each bit on its mid-bit BPS_CLK pulse.
module rx_ctrl_module #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    rx_ctrl_module_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_d_r;
    logic [SYNC_STAGES:0]   valid_r;
    logic                   rx_s;
    logic                   fall_s;

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic [DATA_BITS-1:0]   data_r, data_s;
    logic                   count_r, count_s;
    logic                   done_r, done_s;
    logic                   err_r, err_s;

    // valid_r fills with ones after reset so that rx_s/rx_d hold real line samples
    // before a falling edge is trusted; a line held low across reset release is no start.
    assign rx_s   = sync_r[SYNC_STAGES-1];
    assign fall_s = valid_r[SYNC_STAGES] & rx_d_r & ~rx_s;

    // Line synchronizer, edge-history flop and post-reset flush tracker
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_r  <= {SYNC_STAGES{1'b1}};
            rx_d_r  <= 1'b1;
            valid_r <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.RX_Pin_In};
            rx_d_r  <= rx_s;
            valid_r <= {valid_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            count_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            count_r <= count_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        data_s  = data_r;
        count_s = count_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s && bus.RX_En_Sig) begin
                    state_s = START;
                    count_s = 1'b1;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    count_s = 1'b0;
                end
            end
            START: begin
                if (bus.BPS_CLK) begin
                    if (!rx_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                        count_s = 1'b0;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bus.BPS_CLK) begin
                    shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
                    idx_s   = idx_r + IDX_W'(1);
                    if (idx_r == IDX_W'(DATA_BITS - 1)) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (bus.BPS_CLK) begin
                    if (rx_s) begin
                        data_s = shift_r;
                        done_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                    state_s = IDLE;
                    count_s = 1'b0;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                count_s = 1'b0;
            end
        endcase
    end

    assign bus.Count_Sig   = count_r;
    assign bus.RX_Data     = data_r;
    assign bus.RX_Done_Sig = done_r;
    assign bus.Frame_Err   = err_r;
endmodule
